// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like bus between the execute/memory stages (master) and the
// responder (slave). The optional DSRAM_RAND_STALL_EN build of the responder
// does not change this interface.
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-lane writes and full-word reads on an internal
// word array, with in-order responses after a fixed latency and at most QDEPTH
// requests outstanding.
// Optional build macro DSRAM_RAND_STALL_EN: a 16-bit LFSR randomly withholds
// data_sram_addr_ok to exercise the requester's stall paths.
module data_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned QDEPTH     = 2
) (
    input logic                   clk,
    input logic                   reset,
    data_sram_responder_if.slave  bus
);

    localparam int unsigned     PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned     WORDS    = 2 ** ADDR_WIDTH;
    localparam logic [2:0]      CNT_INIT = 3'(LATENCY - 1);
    localparam logic [PTR_W:0]  QFULL    = (PTR_W + 1)'(QDEPTH);

    logic [31:0] mem [WORDS];

    logic        q_wr_q   [QDEPTH];
    logic        q_wr_d   [QDEPTH];
    logic [31:0] q_data_q [QDEPTH];
    logic [31:0] q_data_d [QDEPTH];
    logic [2:0]  q_cnt_q  [QDEPTH];
    logic [2:0]  q_cnt_d  [QDEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [QDEPTH-1:0]     entry_valid;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_ok;
    logic                  data_ok;
    logic                  accept;
    logic                  unused_bits;

    // Upper address bits alias and the low two bits select a lane downstream.
    assign word_idx    = bus.data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                           bus.data_sram_addr[31:ADDR_WIDTH+2]};

    assign accept  = bus.data_sram_req && addr_ok;
    assign data_ok = (count_q != '0) && (q_cnt_q[head_q] == 3'd0);

    // An entry is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < QDEPTH; g++) begin : g_valid
        logic [PTR_W-1:0] off;
        assign off            = PTR_W'(g) - head_q;
        assign entry_valid[g] = {1'b0, off} < count_q;
    end

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Advance the stall pattern every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    assign addr_ok = (count_q < QFULL) && lfsr_q[0];
`else
    assign addr_ok = count_q < QFULL;
`endif

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = data_ok;
    assign bus.data_sram_rdata   = (data_ok && !q_wr_q[head_q]) ? q_data_q[head_q] : 32'h0;

    // Byte-lane writes at the acceptance edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.data_sram_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Queue next state: countdown of live entries, push at tail, pop at head.
    always_comb begin
        q_wr_d   = q_wr_q;
        q_data_d = q_data_q;
        q_cnt_d  = q_cnt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (entry_valid[i] && (q_cnt_q[i] != 3'd0)) begin
                q_cnt_d[i] = q_cnt_q[i] - 3'd1;
            end
        end

        // The tail slot is free whenever a push is allowed, so this cannot
        // collide with the countdown above. Reads see the pre-edge array.
        if (accept) begin
            q_wr_d[tail_q]   = bus.data_sram_wr;
            q_data_d[tail_q] = mem[word_idx];
            q_cnt_d[tail_q]  = CNT_INIT;
            tail_d           = tail_q + 1'b1;
        end

        if (data_ok) begin
            head_d = head_q + 1'b1;
        end

        if (accept && !data_ok) begin
            count_d = count_q + 1'b1;
        end else if (!accept && data_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Queue state; reset drops every pending response at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_wr_q[i]   <= 1'b0;
                q_data_q[i] <= 32'h0;
                q_cnt_q[i]  <= 3'd0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            q_wr_q   <= q_wr_d;
            q_data_q <= q_data_d;
            q_cnt_q  <= q_cnt_d;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: dut_a (LATENCY 2, QDEPTH 4) for ordering and
// a scoreboard run, dut_b (LATENCY 3, QDEPTH 2) for the full/back-pressure case.
module tb_data_sram_responder;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    data_sram_responder_if bus_a ();
    data_sram_responder_if bus_b ();

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .QDEPTH(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .QDEPTH(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int sel, input logic req, input logic wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            bus_a.data_sram_req   = req;
            bus_a.data_sram_wr    = wr;
            bus_a.data_sram_size  = 2'd2;
            bus_a.data_sram_wstrb = strb;
            bus_a.data_sram_addr  = addr;
            bus_a.data_sram_wdata = wdata;
        end else begin
            bus_b.data_sram_req   = req;
            bus_b.data_sram_wr    = wr;
            bus_b.data_sram_size  = 2'd2;
            bus_b.data_sram_wstrb = strb;
            bus_b.data_sram_addr  = addr;
            bus_b.data_sram_wdata = wdata;
        end
    endtask

    // One isolated request; returns its rdata and the number of falling edges
    // from acceptance until data_ok (-1 if it never came).
    task automatic xact(input int sel, input logic wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat);
        logic ok;
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, strb, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = -1;
        rd  = 32'hx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            ok = (sel == 0) ? bus_a.data_sram_data_ok : bus_b.data_sram_data_ok;
            if (ok) begin
                rd  = (sel == 0) ? bus_a.data_sram_rdata : bus_b.data_sram_rdata;
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus_a.data_sram_addr_ok !== 1'b1) begin bad++;
            $display("FAIL reset_a_addr_ok got=%b want=1", bus_a.data_sram_addr_ok); end
        total++; if (bus_a.data_sram_data_ok !== 1'b0) begin bad++;
            $display("FAIL reset_a_data_ok got=%b want=0", bus_a.data_sram_data_ok); end
        total++; if (bus_a.data_sram_rdata !== 32'h0) begin bad++;
            $display("FAIL reset_a_rdata got=%h want=0", bus_a.data_sram_rdata); end
        total++; if (bus_b.data_sram_addr_ok !== 1'b1) begin bad++;
            $display("FAIL reset_b_addr_ok got=%b want=1", bus_b.data_sram_addr_ok); end
        total++; if (bus_b.data_sram_data_ok !== 1'b0) begin bad++;
            $display("FAIL reset_b_data_ok got=%b want=0", bus_b.data_sram_data_ok); end
        total++; if (bus_b.data_sram_rdata !== 32'h0) begin bad++;
            $display("FAIL reset_b_rdata got=%h want=0", bus_b.data_sram_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        xact(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_a_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_a_rdata got=%h want=0", rd); end
        xact(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL rd_a_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++;
            $display("FAIL rd_a_rdata got=%h want=deadbeef", rd); end
        xact(1, 1'b1, 4'hF, 32'h100, 32'hCAFEF00D, rd, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_b_latency got=%0d want=3", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_b_rdata got=%h want=0", rd); end
        xact(1, 1'b0, 4'h0, 32'h100, 32'h0, rd, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_b_latency got=%0d want=3", lat); end
        total++; if (rd !== 32'hCAFEF00D) begin bad++;
            $display("FAIL rd_b_rdata got=%h want=cafef00d", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int lat;
        xact(0, 1'b1, 4'hF, 32'h200, 32'h11223344, rd, lat);
        xact(0, 1'b1, 4'b0101, 32'h200, 32'hAABBCCDD, rd, lat);
        xact(0, 1'b0, 4'h0, 32'h202, 32'h0, rd, lat);
        total++; if (rd !== 32'h11BB33DD) begin bad++;
            $display("FAIL lanes_rdata got=%h want=11bb33dd", rd); end
        // wstrb of zero is a no-op write that still responds
        xact(0, 1'b1, 4'h0, 32'h200, 32'hFFFFFFFF, rd, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL nostrb_latency got=%0d want=2", lat); end
        xact(0, 1'b0, 4'h0, 32'h203, 32'h0, rd, lat);
        total++; if (rd !== 32'h11BB33DD) begin bad++;
            $display("FAIL nostrb_rdata got=%h want=11bb33dd", rd); end
    endtask

    task automatic test_ordering();
        logic [31:0] vals [4];
        logic [31:0] rd;
        logic exp_ok;
        int lat;
        for (int k = 0; k < 4; k++) begin
            vals[k] = 32'h1111_1111 * (k + 1);
            xact(0, 1'b1, 4'hF, 32'h300 + 4 * k, vals[k], rd, lat);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        // first edge of the loop is the acceptance edge t of read 0
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 3) drive(0, 1'b1, 1'b0, 4'h0, 32'h300 + 4 * (k + 1), 32'h0);
            else drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            exp_ok = (k >= 1) && (k <= 4);
            total++; if (bus_a.data_sram_data_ok !== exp_ok) begin bad++;
                $display("FAIL order_data_ok k=%0d got=%b want=%b", k,
                         bus_a.data_sram_data_ok, exp_ok); end
            if (exp_ok) begin
                total++; if (bus_a.data_sram_rdata !== vals[k-1]) begin bad++;
                    $display("FAIL order_rdata k=%0d got=%h want=%h", k,
                             bus_a.data_sram_rdata, vals[k-1]); end
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] words [2];
        logic [31:0] rd;
        logic exp_addr_ok, exp_data_ok, acc_pending;
        int lat, ni, nr;
        words[0] = 32'h4444_0000;
        words[1] = 32'h4444_0001;
        xact(1, 1'b1, 4'hF, 32'h400, words[0], rd, lat);
        xact(1, 1'b1, 4'hF, 32'h404, words[1], rd, lat);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
        ni = 0; nr = 0; acc_pending = 1'b1;
        // Requests held high: accepted at e0, e1, e4, e5; period-4 pattern
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (acc_pending) ni++;
            if (k == 7) drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            else drive(1, 1'b1, 1'b0, 4'h0, 32'h400 + 4 * (ni % 2), 32'h0);
            @(negedge clk);
            exp_addr_ok = (k % 4 == 0) || (k % 4 == 3);
            exp_data_ok = (k % 4 >= 2);
            total++; if (bus_b.data_sram_addr_ok !== exp_addr_ok) begin bad++;
                $display("FAIL full_addr_ok k=%0d got=%b want=%b", k,
                         bus_b.data_sram_addr_ok, exp_addr_ok); end
            total++; if (bus_b.data_sram_data_ok !== exp_data_ok) begin bad++;
                $display("FAIL full_data_ok k=%0d got=%b want=%b", k,
                         bus_b.data_sram_data_ok, exp_data_ok); end
            if (exp_data_ok) begin
                total++; if (bus_b.data_sram_rdata !== words[nr % 2]) begin bad++;
                    $display("FAIL full_rdata k=%0d got=%h want=%h", k,
                             bus_b.data_sram_rdata, words[nr % 2]); end
                nr++;
            end
            acc_pending = exp_addr_ok && (k != 7);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (bus_b.data_sram_data_ok !== 1'b0) begin bad++;
                $display("FAIL full_extra_resp k=%0d got=%b want=0", k,
                         bus_b.data_sram_data_ok); end
        end
        total++; if (ni !== 4) begin bad++;
            $display("FAIL full_issued got=%0d want=4", ni); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        int lat, seen;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        total++; if (bus_a.data_sram_data_ok !== 1'b0) begin bad++;
            $display("FAIL midrst_data_ok got=%b want=0", bus_a.data_sram_data_ok); end
        total++; if (bus_a.data_sram_addr_ok !== 1'b1) begin bad++;
            $display("FAIL midrst_addr_ok got=%b want=1", bus_a.data_sram_addr_ok); end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_a.data_sram_data_ok) seen++;
        end
        total++; if (seen !== 0) begin bad++;
            $display("FAIL midrst_stale_resp got=%0d want=0", seen); end
        xact(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, lat);
        total++; if (rd !== 32'hDEADBEEF) begin bad++;
            $display("FAIL midrst_retained got=%h want=deadbeef", rd); end
        total++; if (lat !== 2) begin bad++;
            $display("FAIL midrst_latency got=%0d want=2", lat); end
    endtask

    task automatic test_random();
        logic [31:0] model [8];
        logic [31:0] exp_q [$];
        logic [31:0] rd, addr, wdata, e;
        logic [3:0]  strb;
        logic        req, wr;
        int          lat, widx;
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            xact(0, 1'b1, 4'hF, 32'h500 + 4 * i, model[i], rd, lat);
        end
        for (int it = 0; it < 400; it++) begin
            @(posedge clk); #1;
            req   = ($urandom_range(0, 3) != 0);
            wr    = 1'($urandom_range(0, 1));
            strb  = 4'($urandom);
            widx  = $urandom_range(0, 7);
            addr  = 32'h500 + 4 * widx + $urandom_range(0, 3) + ($urandom_range(0, 7) << 12);
            wdata = $urandom;
            drive(0, req, wr, strb, addr, wdata);
            @(negedge clk);
            if (bus_a.data_sram_data_ok) begin
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL rand_unexpected it=%0d got=%h want=none", it,
                             bus_a.data_sram_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_a.data_sram_rdata !== e) begin bad++;
                        $display("FAIL rand_rdata it=%0d got=%h want=%h", it,
                                 bus_a.data_sram_rdata, e); end
                end
            end else begin
                total++; if (bus_a.data_sram_rdata !== 32'h0) begin bad++;
                    $display("FAIL rand_idle_rdata it=%0d got=%h want=0", it,
                             bus_a.data_sram_rdata); end
            end
            if (req && bus_a.data_sram_addr_ok) begin
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model[widx][8*b +: 8] = wdata[8*b +: 8];
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(model[widx]);
                end
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_a.data_sram_data_ok) begin
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL rand_drain_unexpected got=%h want=none",
                             bus_a.data_sram_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_a.data_sram_rdata !== e) begin bad++;
                        $display("FAIL rand_drain_rdata got=%h want=%h",
                                 bus_a.data_sram_rdata, e); end
                end
            end
        end
        total++; if (exp_q.size() !== 0) begin bad++;
            $display("FAIL rand_lost_resp got=%0d want=0 outstanding", exp_q.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_ordering();
        test_full();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
